ssd_scan_ctl: RTL and testbench
===============================

Name: ssd_scan_ctl

Overview:
- Display-side consumer of the four 4-bit digit codes produced by the calculator's output-select logic.
- Time-multiplexes them onto one shared active-low 7-segment bus with four active-low digit enables.
- Snapshots all digits once per frame so an update never tears across a scan.
- Decodes BCD, minus sign and blank codes, with optional leading-zero suppression and per-digit decimal point.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (>=2); counter width = clog2(SCAN_DIV)
LZ_DEFAULT, 1, reset value of the internal leading-zero-suppress shadow bit

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
in0  input  4  digit code, rightmost digit (LSD)
in1  input  4  digit code
in2  input  4  digit code
in3  input  4  digit code, leftmost digit (MSD)
dp_in  input  4  decimal point request per digit, bit k -> digit k, active-high
lz_en  input  1  leading-zero suppression enable
ssd_ctl  output  4  digit enables, active-low, bit k drives digit k
segs  output  8  segments {a,b,c,d,e,f,g,dp}, active-low
frame_tick  output  1  one-cycle pulse on the edge where a new snapshot is loaded

Behaviour:
- Reset (async, rst_n=0), held while low:
  - prescaler cnt=0, sel=0
  - shadow digits = 4'hF (blank), shadow dp = 0, shadow lz = LZ_DEFAULT
  - ssd_ctl=4'b1110, segs=8'hFF, frame_tick=0
- Prescaler: cnt counts 0..SCAN_DIV-1 and wraps. tick is asserted when cnt==SCAN_DIV-1.
- On tick, sel advances 0->1->2->3->0.
- Snapshot: on a tick with sel==3, in0..in3, dp_in and lz_en are loaded into the shadow registers on the same edge sel wraps to 0. frame_tick=1 for exactly that one cycle.
- Inputs are ignored at all other times. Changes mid-frame appear only from the next frame.
- The first frame after reset therefore shows blank on all digits.
- Outputs are registered and update on the same edge sel changes, so ssd_ctl, segs and sel are always consistent:
  - ssd_ctl = ~(4'b0001 << sel)
  - segs = decode(shadow[sel]), with the dp bit cleared when shadow dp[sel]=1
- Decode (active-low):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09
  - 4'hA = minus sign, FD (g only)
  - 4'hB..4'hF = blank, FF
- Leading-zero suppression (shadow lz=1):
  - Digit 3 is blanked if its code is 0.
  - Digit 2 is blanked if digit 3 is blanked and its code is 0.
  - Digit 1 is blanked under the same rule relative to digit 2.
  - Digit 0 is never suppressed.
  - Minus and blank codes do not count as zero, and blank codes do not propagate suppression.
  - The dp of a suppressed digit is still shown.
- Boundaries:
  - cnt wrap and sel wrap happen on the same edge.
  - rst_n asserted mid-frame returns all state to reset values immediately. After release, scanning restarts at sel=0 with cnt=0.
  - No state besides cnt, sel, the shadow registers and the output registers.

Test Plan:
1. SCAN_DIV=4; hold rst_n=0, then release. Required: ssd_ctl=1110, segs=FF while in reset. After release, ssd_ctl steps 1101, 1011, 0111, 1110 every 4 clocks. frame_tick pulses once per 16 clocks on the 0111->1110 edge. segs=FF for the whole first frame.
2. in3..in0 = 1,2,3,4; dp_in=0, lz_en=0. Required in the second frame: digit0=99, digit1=0D, digit2=25, digit3=9F.
3. in3..in0 = 0,0,A,5; lz_en=1. Required: digit3=FF, digit2=FF, digit1=FD, digit0=49. Repeat with lz_en=0: digit3=03, digit2=03.
4. in3..in0 = 0,0,0,0; lz_en=1; dp_in=0100. Required: digits 3 and 1 = FF, digit2=FE (blank, dp lit), digit0=03.
5. Change in0 from 1 to 7 while sel=1. Required: digit0 keeps showing 9F for the rest of that frame and shows 1F only after the next frame_tick. Code 4'hC gives FF.
6. Assert rst_n low for 1 cycle while sel=2. Required: ssd_ctl=1110 and segs=FF asynchronously. After release, scanning restarts from sel=0 with a blank first frame.

Source files
------------

// File: rtl/ssd_scan_ctl.sv
// Four-digit multiplexed 7-segment scan controller.
// Snapshots the digit codes once per frame, then scans them onto a shared
// active-low segment bus with active-low digit enables.
`timescale 1ns/1ps

module ssd_scan_ctl #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          LZ_DEFAULT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] dp_in,
  input  logic       lz_en,
  output logic [3:0] ssd_ctl,
  output logic [7:0] segs,
  output logic       frame_tick
);

  localparam int unsigned    CntW   = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  // Prescaler and slot select.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            tick, snap;

  // Per-frame shadow of the inputs.
  logic [3:0][3:0] dig_q, dig_d;
  logic [3:0]      dp_q, dp_d;
  logic            lz_q, lz_d;

  // Registered outputs.
  logic [3:0] ssd_ctl_q, ssd_ctl_d;
  logic [7:0] segs_q, segs_d;
  logic       frame_tick_q, frame_tick_d;

  // Active-low segment decode {a,b,c,d,e,f,g,dp}; dp is left off here.
  function automatic logic [7:0] decode(input logic [3:0] code);
    logic [7:0] s;
    case (code)
      4'h0:    s = 8'h03;
      4'h1:    s = 8'h9F;
      4'h2:    s = 8'h25;
      4'h3:    s = 8'h0D;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h49;
      4'h6:    s = 8'h41;
      4'h7:    s = 8'h1F;
      4'h8:    s = 8'h01;
      4'h9:    s = 8'h09;
      4'hA:    s = 8'hFD;  // minus: segment g only
      default: s = 8'hFF;  // blank codes
    endcase
    return s;
  endfunction

  // State register: prescaler, select, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      dig_q        <= {4{4'hF}};
      dp_q         <= 4'b0000;
      lz_q         <= LZ_DEFAULT;
      ssd_ctl_q    <= 4'b1110;
      segs_q       <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      dig_q        <= dig_d;
      dp_q         <= dp_d;
      lz_q         <= lz_d;
      ssd_ctl_q    <= ssd_ctl_d;
      segs_q       <= segs_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Next state: prescaler wrap, slot advance, and end-of-frame snapshot.
  always_comb begin
    tick  = (cnt_q == CntMax);
    snap  = tick && (sel_q == 2'd3);
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
    sel_d = tick ? sel_q + 2'd1 : sel_q;
    dig_d = dig_q;
    dp_d  = dp_q;
    lz_d  = lz_q;
    if (snap) begin
      dig_d = {in3, in2, in1, in0};
      dp_d  = dp_in;
      lz_d  = lz_en;
    end
  end

  // Output next values, derived from the next select and next shadow so the
  // registered outputs always match the slot being shown.
  logic [3:0] sup;
  always_comb begin
    // A digit is suppressed only if it is zero and everything left of it was too.
    sup[3] = lz_d && (dig_d[3] == 4'h0);
    sup[2] = sup[3] && (dig_d[2] == 4'h0);
    sup[1] = sup[2] && (dig_d[1] == 4'h0);
    sup[0] = 1'b0;

    ssd_ctl_d    = ~(4'b0001 << sel_d);
    segs_d       = sup[sel_d] ? 8'hFF : decode(dig_d[sel_d]);
    if (dp_d[sel_d]) begin
      segs_d[0] = 1'b0;
    end
    frame_tick_d = snap;
  end

  assign ssd_ctl    = ssd_ctl_q;
  assign segs       = segs_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Directed bench for ssd_scan_ctl with a per-slot scoreboard.
`timescale 1ns/1ps

module tb_ssd_scan_ctl;

  localparam int unsigned ScanDiv = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] in0, in1, in2, in3, dp_in;
  logic       lz_en;
  logic [3:0] ssd_ctl;
  logic [7:0] segs;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;

  // Expected {ssd_ctl, segs} per slot, in display order.
  logic [11:0] sb_q[$];

  always #5 clk = ~clk;

  ssd_scan_ctl #(
    .SCAN_DIV  (ScanDiv),
    .LZ_DEFAULT(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .dp_in     (dp_in),
    .lz_en     (lz_en),
    .ssd_ctl   (ssd_ctl),
    .segs      (segs),
    .frame_tick(frame_tick)
  );

  function automatic logic [7:0] ref_dec(input logic [3:0] c);
    case (c)
      4'h0: return 8'h03;
      4'h1: return 8'h9F;
      4'h2: return 8'h25;
      4'h3: return 8'h0D;
      4'h4: return 8'h99;
      4'h5: return 8'h49;
      4'h6: return 8'h41;
      4'h7: return 8'h1F;
      4'h8: return 8'h01;
      4'h9: return 8'h09;
      4'hA: return 8'hFD;
      default: return 8'hFF;
    endcase
  endfunction

  // Reference segment pattern for digit k given the current inputs.
  function automatic logic [7:0] ref_segs(input int k);
    logic [3:0] codes [4];
    logic       supp;
    logic [7:0] r;
    codes[0] = in0;
    codes[1] = in1;
    codes[2] = in2;
    codes[3] = in3;
    supp = lz_en;
    for (int j = 3; j >= k; j--) begin
      supp = supp && (codes[j] == 4'h0);
    end
    if (k == 0) supp = 1'b0;
    r = supp ? 8'hFF : ref_dec(codes[k]);
    if (dp_in[k]) r[0] = 1'b0;
    return r;
  endfunction

  task automatic push_frame();
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back({4'(~(4'b0001 << k)), ref_segs(k)});
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the current slot against the scoreboard head.
  task automatic check_slot(input string tag, input int k);
    logic [11:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s slot%0d: observed empty scoreboard expected entry", tag, k);
    end else begin
      exp = sb_q.pop_front();
      chk($sformatf("%s slot%0d", tag, k), {4'h0, ssd_ctl, segs}, {4'h0, exp});
    end
    chk($sformatf("%s tick%0d", tag, k), {15'h0, frame_tick}, {15'h0, k == 0});
  endtask

  task automatic check_slots(input string tag, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      check_slot(tag, k);
      if (k < hi) repeat (ScanDiv) @(negedge clk);
    end
  endtask

  // Advance to the negedge where frame_tick is high (bounded).
  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s wait: observed no frame_tick expected one within 40 cycles", tag);
    end
  endtask

  // First frame after a reset release: blank scan, ends on the first frame_tick.
  task automatic first_frame(input string tag);
    logic [3:0] ectl;
    for (int i = 1; i <= 4 * ScanDiv; i++) begin
      @(negedge clk);
      ectl = ~(4'b0001 << ((i / ScanDiv) % 4));
      chk($sformatf("%s ctl c%0d", tag, i), {12'h0, ssd_ctl}, {12'h0, ectl});
      chk($sformatf("%s tick c%0d", tag, i), {15'h0, frame_tick},
          {15'h0, i == 4 * ScanDiv});
      if (i < 4 * ScanDiv) chk($sformatf("%s blank c%0d", tag, i), {8'h0, segs}, 16'h00FF);
    end
  endtask

  initial begin
    // 1: reset state and first blank frame
    {in3, in2, in1, in0} = 16'h1234;
    dp_in = 4'b0000;
    lz_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst ctl", {12'h0, ssd_ctl}, 16'h000E);
    chk("rst segs", {8'h0, segs}, 16'h00FF);
    chk("rst tick", {15'h0, frame_tick}, 16'h0000);
    repeat (3) @(negedge clk);
    chk("rst hold ctl", {12'h0, ssd_ctl}, 16'h000E);
    chk("rst hold segs", {8'h0, segs}, 16'h00FF);
    push_frame();
    rst_n = 1'b1;
    first_frame("t1");

    // 2: plain digits 1,2,3,4
    check_slots("t2", 0, 3);

    // 3: minus and leading zeros, suppression on then off
    {in3, in2, in1, in0} = 16'h00A5;
    lz_en = 1'b1;
    push_frame();
    wait_frame("t3a");
    check_slots("t3a", 0, 3);
    lz_en = 1'b0;
    push_frame();
    wait_frame("t3b");
    check_slots("t3b", 0, 3);

    // 4: all zeros with suppression, dp on a suppressed digit
    {in3, in2, in1, in0} = 16'h0000;
    lz_en = 1'b1;
    dp_in = 4'b0100;
    push_frame();
    wait_frame("t4");
    check_slots("t4", 0, 3);

    // 5: mid-frame change is deferred; code C is blank
    {in3, in2, in1, in0} = 16'hCCC1;
    lz_en = 1'b0;
    dp_in = 4'b0000;
    push_frame();
    wait_frame("t5a");
    check_slots("t5a", 0, 0);
    repeat (ScanDiv) @(negedge clk);
    in0 = 4'h7;
    push_frame();
    check_slots("t5a", 1, 3);
    wait_frame("t5b");
    check_slots("t5b", 0, 3);

    // 6: short reset pulse while sel==2
    wait_frame("t6");
    repeat (2 * ScanDiv) @(negedge clk);
    chk("t6 pre ctl", {12'h0, ssd_ctl}, 16'h000B);
    {in3, in2, in1, in0} = 16'h9876;
    dp_in = 4'b1001;
    lz_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6 async ctl", {12'h0, ssd_ctl}, 16'h000E);
    chk("t6 async segs", {8'h0, segs}, 16'h00FF);
    chk("t6 async tick", {15'h0, frame_tick}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame();
    first_frame("t6");
    check_slots("t6", 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
